arc4_seq: RTL and testbench

ARC4_SEQ -- requirements
Module: arc4_seq

---
 rtl/arc4_pkg.sv | 21 ++
 rtl/arc4_seq_smem_mux.sv | 51 +++++
 rtl/arc4_seq.sv | 128 ++++++++++++
 tb/tb_arc4_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/arc4_pkg.sv
// arc4_pkg: shared state encoding and phase codes for the ARC4 sequencer.
//   state_t  - sequencer FSM states
//   PH_*     - phase codes seen on arc4_seq.phase and used as the mux select
package arc4_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GO_INIT,
    ST_WT_INIT,
    ST_GO_KSA,
    ST_WT_KSA,
    ST_GO_PRGA,
    ST_WT_PRGA
  } state_t;

  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_INIT = 2'd1;
  localparam logic [1:0] PH_KSA  = 2'd2;
  localparam logic [1:0] PH_PRGA = 2'd3;

endpackage

// File: rtl/arc4_seq_smem_mux.sv
// smem_mux: S-memory port arbiter. The engine owning the current phase
// drives the memory; in idle the host read address passes through and
// writes are blocked.
//   phase                      - owner select (PH_* codes)
//   init_/ksa_/prga_ addr/wrdata/wren - engine memory requests
//   host_addr                  - host read address (idle only)
//   s_addr/s_wrdata/s_wren     - shared S-memory port
module smem_mux
  import arc4_pkg::*;
(
  input  logic [1:0] phase,
  input  logic [7:0] init_addr,
  input  logic [7:0] init_wrdata,
  input  logic       init_wren,
  input  logic [7:0] ksa_addr,
  input  logic [7:0] ksa_wrdata,
  input  logic       ksa_wren,
  input  logic [7:0] prga_addr,
  input  logic [7:0] prga_wrdata,
  input  logic       prga_wren,
  input  logic [7:0] host_addr,
  output logic [7:0] s_addr,
  output logic [7:0] s_wrdata,
  output logic       s_wren
);

  always_comb begin
    s_addr   = host_addr;
    s_wrdata = 8'h00;
    s_wren   = 1'b0;
    case (phase)
      PH_INIT: begin
        s_addr   = init_addr;
        s_wrdata = init_wrdata;
        s_wren   = init_wren;
      end
      PH_KSA: begin
        s_addr   = ksa_addr;
        s_wrdata = ksa_wrdata;
        s_wren   = ksa_wren;
      end
      PH_PRGA: begin
        s_addr   = prga_addr;
        s_wrdata = prga_wrdata;
        s_wren   = prga_wren;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/arc4_seq.sv
// arc4_seq: runs the init, ksa and prga engines strictly one after another
// for each accepted start request and hands the S-memory to the active one.
//   clk, rst        - clock, synchronous active-high reset
//   en / rdy        - start request / idle flag (en only honoured when rdy=1)
//   phase           - 0 idle, 1 init, 2 ksa, 3 prga
//   x_en / x_rdy    - engine start pulses / engine idle flags
//   x_addr/wrdata/wren, host_addr - memory requests into the mux
//   s_addr/s_wrdata/s_wren        - shared S-memory port
//
// state       | meaning
// ST_IDLE     | rdy=1, host owns memory, waiting for en
// ST_GO_INIT  | pulse init_en once init_rdy=1
// ST_WT_INIT  | wait for init engine to go busy then idle
// ST_GO_KSA   | pulse ksa_en once ksa_rdy=1
// ST_WT_KSA   | wait for ksa engine to go busy then idle
// ST_GO_PRGA  | pulse prga_en once prga_rdy=1
// ST_WT_PRGA  | wait for prga engine to go busy then idle
module arc4_seq
  import arc4_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       rdy,
  output logic [1:0] phase,
  output logic       init_en,
  output logic       ksa_en,
  output logic       prga_en,
  input  logic       init_rdy,
  input  logic       ksa_rdy,
  input  logic       prga_rdy,
  input  logic [7:0] init_addr,
  input  logic [7:0] ksa_addr,
  input  logic [7:0] prga_addr,
  input  logic [7:0] init_wrdata,
  input  logic [7:0] ksa_wrdata,
  input  logic [7:0] prga_wrdata,
  input  logic       init_wren,
  input  logic       ksa_wren,
  input  logic       prga_wren,
  input  logic [7:0] host_addr,
  output logic [7:0] s_addr,
  output logic [7:0] s_wrdata,
  output logic       s_wren
);

  state_t state;
  logic   busy_seen;

  // rdy and phase are registered alongside state so they always match it.
  // busy_seen guards against an engine whose rdy has not yet dropped in
  // the first wait cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy_seen <= 1'b0;
      rdy       <= 1'b1;
      phase     <= PH_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (en) begin
          state     <= ST_GO_INIT;
          busy_seen <= 1'b0;
          rdy       <= 1'b0;
          phase     <= PH_INIT;
        end
        ST_GO_INIT: if (init_rdy) state <= ST_WT_INIT;
        ST_WT_INIT: begin
          if (!init_rdy) busy_seen <= 1'b1;
          else if (busy_seen) begin
            state     <= ST_GO_KSA;
            busy_seen <= 1'b0;
            phase     <= PH_KSA;
          end
        end
        ST_GO_KSA: if (ksa_rdy) state <= ST_WT_KSA;
        ST_WT_KSA: begin
          if (!ksa_rdy) busy_seen <= 1'b1;
          else if (busy_seen) begin
            state     <= ST_GO_PRGA;
            busy_seen <= 1'b0;
            phase     <= PH_PRGA;
          end
        end
        ST_GO_PRGA: if (prga_rdy) state <= ST_WT_PRGA;
        ST_WT_PRGA: begin
          if (!prga_rdy) busy_seen <= 1'b1;
          else if (busy_seen) begin
            state     <= ST_IDLE;
            busy_seen <= 1'b0;
            rdy       <= 1'b1;
            phase     <= PH_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          busy_seen <= 1'b0;
          rdy       <= 1'b1;
          phase     <= PH_IDLE;
        end
      endcase
    end
  end

  // The pulse must land in the same cycle the engine reports idle, and the
  // GO state is left on that same edge, so each pulse is exactly one cycle.
  assign init_en = (state == ST_GO_INIT) && init_rdy;
  assign ksa_en  = (state == ST_GO_KSA)  && ksa_rdy;
  assign prga_en = (state == ST_GO_PRGA) && prga_rdy;

  smem_mux u_smem_mux (
    .phase       (phase),
    .init_addr   (init_addr),
    .init_wrdata (init_wrdata),
    .init_wren   (init_wren),
    .ksa_addr    (ksa_addr),
    .ksa_wrdata  (ksa_wrdata),
    .ksa_wren    (ksa_wren),
    .prga_addr   (prga_addr),
    .prga_wrdata (prga_wrdata),
    .prga_wren   (prga_wren),
    .host_addr   (host_addr),
    .s_addr      (s_addr),
    .s_wrdata    (s_wrdata),
    .s_wren      (s_wren)
  );

endmodule

// File: tb/tb_arc4_seq.sv
// tb_arc4_seq: directed bench for arc4_seq with simple busy-counter
// engine models (optional one-cycle-late busy, optional forced not-ready).
module tb_arc4_seq;

  logic       clk = 1'b0;
  logic       rst, en;
  logic       rdy;
  logic [1:0] phase;
  logic       init_en, ksa_en, prga_en;
  logic       init_rdy, ksa_rdy, prga_rdy;
  logic [7:0] init_addr, ksa_addr, prga_addr;
  logic [7:0] init_wrdata, ksa_wrdata, prga_wrdata;
  logic       init_wren, ksa_wren, prga_wren;
  logic [7:0] host_addr;
  logic [7:0] s_addr, s_wrdata;
  logic       s_wren;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arc4_seq dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .phase(phase),
    .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en),
    .init_rdy(init_rdy), .ksa_rdy(ksa_rdy), .prga_rdy(prga_rdy),
    .init_addr(init_addr), .ksa_addr(ksa_addr), .prga_addr(prga_addr),
    .init_wrdata(init_wrdata), .ksa_wrdata(ksa_wrdata), .prga_wrdata(prga_wrdata),
    .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
    .host_addr(host_addr),
    .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren)
  );

  // engine models: index 0 init, 1 ksa, 2 prga
  int   len [3];
  bit   late[3];
  int   cnt [3];
  bit   pend[3];
  logic init_hold;
  logic [2:0] eng_en;
  assign eng_en = {prga_en, ksa_en, init_en};

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        cnt[i]  <= 0;
        pend[i] <= 1'b0;
      end else if (eng_en[i]) begin
        if (late[i]) pend[i] <= 1'b1;
        else         cnt[i]  <= len[i];
      end else if (pend[i]) begin
        pend[i] <= 1'b0;
        cnt[i]  <= len[i];
      end else if (cnt[i] != 0) begin
        cnt[i] <= cnt[i] - 1;
      end
    end
  end

  assign init_rdy = (cnt[0] == 0) && !init_hold;
  assign ksa_rdy  = (cnt[1] == 0);
  assign prga_rdy = (cnt[2] == 0);

  // observation: pulse counts, phase change log, cycles per phase
  int   n_init = 0, n_ksa = 0, n_prga = 0;
  int   ph_log[$];
  int   ph_cyc[4] = '{0, 0, 0, 0};
  logic [1:0] last_ph = 2'd0;

  always @(posedge clk) begin
    if (init_en === 1'b1) n_init++;
    if (ksa_en  === 1'b1) n_ksa++;
    if (prga_en === 1'b1) n_prga++;
    if (!$isunknown(phase)) begin
      ph_cyc[phase]++;
      if (phase != last_ph) begin
        ph_log.push_back(int'(phase));
        last_ph = phase;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_phase(input logic [1:0] p, input int budget, input string tag);
    int n = 0;
    while (phase !== p && n < budget) begin
      tick();
      n++;
    end
    chk(tag, {30'd0, phase}, {30'd0, p});
  endtask

  task automatic wait_rdy(input int budget, input string tag);
    int n = 0;
    while (rdy !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, rdy}, 32'd1);
  endtask

  initial begin
    int s_init, s_ksa, s_prga, l1;
    int c1[4];

    rst = 1'b1; en = 1'b0; init_hold = 1'b0;
    host_addr = 8'hC3;
    init_addr = 8'h11; init_wrdata = 8'h21; init_wren = 1'b1;
    ksa_addr  = 8'h5A; ksa_wrdata  = 8'hA5; ksa_wren  = 1'b1;
    prga_addr = 8'h7E; prga_wrdata = 8'hE7; prga_wren = 1'b1;
    len  = '{257, 768, 100};
    late = '{0, 0, 0};

    tick(); tick();
    chk("rst_rdy",    {31'd0, rdy},     32'd1);
    chk("rst_phase",  {30'd0, phase},   32'd0);
    chk("rst_init_en",{31'd0, init_en}, 32'd0);
    chk("rst_s_wren", {31'd0, s_wren},  32'd0);
    chk("rst_s_wrdata",{24'd0, s_wrdata}, 32'd0);
    chk("idle_s_addr",{24'd0, s_addr},  32'hC3);

    rst = 1'b0;
    tick();
    chk("idle_hold_phase", {30'd0, phase}, 32'd0);

    // run 1: long engines, full sequence
    s_init = n_init; s_ksa = n_ksa; s_prga = n_prga;
    l1 = ph_log.size();
    c1 = ph_cyc;
    en = 1'b1; tick(); en = 1'b0;
    chk("r1_init_en_lat", {31'd0, init_en}, 32'd1);
    chk("r1_phase1",      {30'd0, phase},   32'd1);
    chk("r1_rdy_busy",    {31'd0, rdy},     32'd0);
    chk("r1_init_addr",   {24'd0, s_addr},  32'h11);
    chk("r1_init_wrdata", {24'd0, s_wrdata},32'h21);
    chk("r1_init_wren",   {31'd0, s_wren},  32'd1);
    tick();
    chk("r1_init_en_once",{31'd0, init_en}, 32'd0);

    wait_phase(2'd2, 400, "r1_reach_ksa");
    chk("r1_ksa_addr",   {24'd0, s_addr},  32'h5A);
    chk("r1_ksa_wrdata", {24'd0, s_wrdata},32'hA5);
    chk("r1_ksa_wren",   {31'd0, s_wren},  32'd1);
    en = 1'b1; tick(); en = 1'b0;
    chk("r1_en_ignored_phase", {30'd0, phase}, 32'd2);

    wait_phase(2'd3, 1000, "r1_reach_prga");
    chk("r1_prga_addr", {24'd0, s_addr}, 32'h7E);
    wait_rdy(300, "r1_done_rdy");
    chk("r1_done_phase",  {30'd0, phase},  32'd0);
    chk("r1_done_s_addr", {24'd0, s_addr}, 32'hC3);
    chk("r1_done_s_wren", {31'd0, s_wren}, 32'd0);
    chk("r1_init_pulses", n_init - s_init, 32'd1);
    chk("r1_ksa_pulses",  n_ksa  - s_ksa,  32'd1);
    chk("r1_prga_pulses", n_prga - s_prga, 32'd1);

    // run 2: back-to-back start, engines drop rdy one cycle late
    s_init = n_init; s_ksa = n_ksa; s_prga = n_prga;
    len  = '{3, 3, 3};
    late = '{1, 1, 1};
    en = 1'b1; tick(); en = 1'b0;
    chk("r1_log_len", ph_log.size() - l1, 32'd4);
    chk("r1_log_0", ph_log[l1],   32'd1);
    chk("r1_log_1", ph_log[l1+1], 32'd2);
    chk("r1_log_2", ph_log[l1+2], 32'd3);
    chk("r1_log_3", ph_log[l1+3], 32'd0);
    chk("r1_cyc_init", ph_cyc[1] - c1[1], 32'd259);
    chk("r1_cyc_ksa",  ph_cyc[2] - c1[2], 32'd770);
    chk("r1_cyc_prga", ph_cyc[3] - c1[3], 32'd102);
    chk("r2_b2b_phase",   {30'd0, phase},   32'd1);
    chk("r2_b2b_init_en", {31'd0, init_en}, 32'd1);
    tick();
    chk("r2_stale_rdy_wt1", {30'd0, phase}, 32'd1);
    tick();
    chk("r2_stale_rdy_wt2", {30'd0, phase}, 32'd1);
    chk("r2_no_repulse", {31'd0, init_en}, 32'd0);
    wait_rdy(100, "r2_done_rdy");
    chk("r2_init_pulses", n_init - s_init, 32'd1);
    chk("r2_ksa_pulses",  n_ksa  - s_ksa,  32'd1);
    chk("r2_prga_pulses", n_prga - s_prga, 32'd1);

    // run 3: reset in the middle of ksa
    len  = '{50, 50, 50};
    late = '{0, 0, 0};
    en = 1'b1; tick(); en = 1'b0;
    wait_phase(2'd2, 200, "r3_reach_ksa");
    tick();
    chk("r3_ksa_wren", {31'd0, s_wren}, 32'd1);
    rst = 1'b1; tick();
    chk("r3_rst_rdy",    {31'd0, rdy},      32'd1);
    chk("r3_rst_phase",  {30'd0, phase},    32'd0);
    chk("r3_rst_s_wren", {31'd0, s_wren},   32'd0);
    chk("r3_rst_s_addr", {24'd0, s_addr},   32'hC3);
    chk("r3_rst_wrdata", {24'd0, s_wrdata}, 32'd0);

    // run 4: restart after reset with init engine not ready for 5 cycles
    rst = 1'b0;
    init_hold = 1'b1;
    s_init = n_init; s_ksa = n_ksa; s_prga = n_prga;
    en = 1'b1; tick(); en = 1'b0;
    chk("r4_restart_phase", {30'd0, phase}, 32'd1);
    chk("r4_withheld_0", {31'd0, init_en}, 32'd0);
    for (int i = 1; i < 5; i++) begin
      tick();
      chk($sformatf("r4_withheld_%0d", i), {31'd0, init_en}, 32'd0);
    end
    init_hold = 1'b0;
    #1;
    chk("r4_pulse_on_rdy", {31'd0, init_en}, 32'd1);
    tick();
    chk("r4_pulse_once", {31'd0, init_en}, 32'd0);
    chk("r4_wt_phase",   {30'd0, phase},   32'd1);
    wait_rdy(300, "r4_done_rdy");
    chk("r4_init_pulses", n_init - s_init, 32'd1);
    chk("r4_ksa_pulses",  n_ksa  - s_ksa,  32'd1);
    chk("r4_prga_pulses", n_prga - s_prga, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
